// File: rtl/csa_pkg.sv
// Shared constants, block-count helper and candidate record for the carry-select adder.
package csa_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned BLK_DEF   = 4;

  // Block count; a zero block width yields zero so elaboration checks can report it cleanly.
  function automatic int unsigned nblk(input int unsigned width, input int unsigned blk);
    return (blk == 0) ? 0 : width / blk;
  endfunction

  // Per-block candidate record at the default block width.
  typedef struct packed {
    logic [BLK_DEF-1:0] sum0;
    logic               c0;
    logic [BLK_DEF-1:0] sum1;
    logic               c1;
  } cand_t;

endpackage

// File: rtl/csel_block.sv
// One carry-select block: sums for both possible carry-ins, evaluated in parallel.
module csel_block
  import csa_pkg::*;
#(
  parameter int unsigned BLK = BLK_DEF
) (
  input  logic [BLK-1:0] a_blk,
  input  logic [BLK-1:0] b_blk,
  output logic [BLK-1:0] sum0,
  output logic           c0,
  output logic [BLK-1:0] sum1,
  output logic           c1
);

  assign {c0, sum0} = (BLK+1)'(a_blk) + (BLK+1)'(b_blk);
  assign {c1, sum1} = (BLK+1)'(a_blk) + (BLK+1)'(b_blk) + (BLK+1)'(1);

endmodule

// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined carry-select adder with valid/ready on both sides.
// Define CSA_SUB_EN to add the 'sub' port (a - b computed as a + ~b + 1).
module csel_adder_pipe
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned BLK   = BLK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NBLK = nblk(WIDTH, BLK);

  if (BLK < 1) begin : g_bad_blk
    $error("csel_adder_pipe: BLK must be at least 1");
  end else if ((WIDTH % BLK) != 0) begin : g_bad_width
    $error("csel_adder_pipe: WIDTH must be a multiple of BLK");
  end

  typedef struct packed {
    logic [BLK-1:0] sum0;
    logic           c0;
    logic [BLK-1:0] sum1;
    logic           c1;
  } blk_cand_t;

  logic [WIDTH-1:0]           b_eff;
  logic                       cin_eff;
  blk_cand_t [NBLK-1:0]       cand_c;
  blk_cand_t [NBLK-1:0]       s1_cand;
  logic                       s1_cin;
  logic                       s1_v;
  logic                       s2_ready_c;
  logic [WIDTH-1:0]           sum_c;
  logic                       cout_c;

  // Subtraction folds into the adder: invert b and force the carry-in.
`ifdef CSA_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic [BLK-1:0] s0, s1;
    logic           c0, c1;
    csel_block #(.BLK(BLK)) u_blk (
      .a_blk (a[k*BLK +: BLK]),
      .b_blk (b_eff[k*BLK +: BLK]),
      .sum0  (s0),
      .c0    (c0),
      .sum1  (s1),
      .c1    (c1)
    );
    assign cand_c[k] = '{sum0: s0, c0: c0, sum1: s1, c1: c1};
  end

  assign s2_ready_c = !out_valid || out_ready;
  assign in_ready   = !s1_v || s2_ready_c;

  // Stage 1: capture both candidates per block plus the effective carry-in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_cin  <= 1'b0;
      s1_cand <= '0;
    end else if (in_valid && in_ready) begin
      s1_v    <= 1'b1;
      s1_cin  <= cin_eff;
      s1_cand <= cand_c;
    end else if (s2_ready_c) begin
      s1_v    <= 1'b0;
    end
  end

  // Carry ripples block to block, each block just picking its precomputed candidate.
  always_comb begin : p_select
    logic carry;
    carry = s1_cin;
    sum_c = '0;
    for (int k = 0; k < NBLK; k++) begin
      if (carry) begin
        sum_c[k*BLK +: BLK] = s1_cand[k].sum1;
        carry               = s1_cand[k].c1;
      end else begin
        sum_c[k*BLK +: BLK] = s1_cand[k].sum0;
        carry               = s1_cand[k].c0;
      end
    end
    cout_c = carry;
  end

  // Stage 2: result register, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (s2_ready_c) begin
      out_valid <= s1_v;
      if (s1_v) begin
        sum  <= sum_c;
        cout <= cout_c;
      end
    end
  end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Bench for csel_adder_pipe: queue-based reference model plus literal spot checks.
module tb_csel_adder_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;

  logic        iv8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        cin8 = 1'b0;
  logic        ir8a, ir8b, ov8a, ov8b, co8a, co8b;
  logic [7:0]  s8a, s8b;

  always #5 clk = ~clk;

  csel_adder_pipe #(.WIDTH(16), .BLK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef CSA_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  csel_adder_pipe #(.WIDTH(8), .BLK(4)) dut8a (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8a),
    .a(a8), .b(b8), .cin(cin8),
`ifdef CSA_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(ov8a), .out_ready(1'b1), .sum(s8a), .cout(co8a)
  );

  csel_adder_pipe #(.WIDTH(8), .BLK(2)) dut8b (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8b),
    .a(a8), .b(b8), .cin(cin8),
`ifdef CSA_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(ov8b), .out_ready(1'b1), .sum(s8b), .cout(co8b)
  );

  typedef struct {
    logic [16:0] res;
    int          stp;
    logic        haslit;
    logic [16:0] lit;
  } ent_t;

  ent_t q[$];
  int   stp    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference arithmetic: plain 17-bit addition, subtraction as a + ~b + 1.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    if (s) return 17'(x) + 17'(~y) + 17'd1;
    return 17'(x) + 17'(y) + 17'(c);
  endfunction

  // One cycle: drive inputs, compare outputs against the in-flight queue, update the model.
  task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic ic, input logic is, input logic ordy,
                      input logic haslit, input logic [16:0] lit, output logic acc);
    ent_t e;
    logic se;
    logic exp_ov;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    out_ready = ordy;
`ifdef CSA_SUB_EN
    sub = is;
    se  = is;
`else
    se  = 1'b0;
`endif
    #1;
    chk("in_ready", 17'(in_ready), 17'(!(q.size() == 2 && !ordy)));
    exp_ov = (q.size() > 0) && (stp - q[0].stp >= 2);
    chk("out_valid", 17'(out_valid), 17'(exp_ov));
    if (out_valid && q.size() > 0) chk("result", {cout, sum}, q[0].res);
    if (out_valid && ordy && q.size() > 0) begin
      e = q.pop_front();
      if (e.haslit) chk("literal", {cout, sum}, e.lit);
    end
    acc = iv && in_ready;
    if (acc) begin
      e.res    = model(ia, ib, ic, se);
      e.stp    = stp;
      e.haslit = haslit;
      e.lit    = lit;
      q.push_back(e);
    end
    stp++;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ordy, 1'b0, 17'h0, acc);
  endtask

  initial begin
    logic acc;
    // Reset state.
    #12;
    chk("rst_in_ready", 17'(in_ready), 17'd1);
    chk("rst_out_valid", 17'(out_valid), 17'd0);
    chk("rst_sum", {cout, sum}, 17'h0);
    @(negedge clk);
    rst = 1'b0;

    // Narrow instances: 8/4 and 8/2 block splits.
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'h6E; b8 = 8'h77; cin8 = 1'b0;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    #1;
    chk("w8b4_valid", 17'(ov8a), 17'd1);
    chk("w8b4_6e77", 17'({co8a, s8a}), 17'h0E5);
    chk("w8b2_6e77", 17'({co8b, s8b}), 17'h0E5);
    @(negedge clk);
    #1;
    chk("w8b2_valid", 17'(ov8b), 17'd1);
    chk("w8b4_8080", 17'({co8a, s8a}), 17'h101);
    chk("w8b2_8080", 17'({co8b, s8b}), 17'h101);

    // Basic latency and full-chain carries.
    step(1'b1, 16'h0006, 16'h0006, 1'b0, 1'b0, 1'b1, 1'b1, 17'h0000C, acc);
    idle(3, 1'b1);
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 17'h10000, acc);
    step(1'b1, 16'h0FFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 17'h01000, acc);
    step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 17'h10000, acc);
    idle(3, 1'b1);

    // Back-to-back stream with an output stall.
    step(1'b1, 16'h00EE, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b1, 17'h000F5, acc);
    step(1'b1, 16'h0002, 16'h0009, 1'b0, 1'b0, 1'b1, 1'b1, 17'h0000B, acc);
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b1, 17'h05555, acc);
    acc = 1'b0;
    for (int i = 0; i < 5 && !acc; i++)
      step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 1'b1, 17'h05555, acc);
    chk("stream_accept", 17'(acc), 17'd1);
    idle(4, 1'b1);

`ifdef CSA_SUB_EN
    step(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 1'b1, 17'h0FFFE, acc);
    step(1'b1, 16'h0009, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b1, 17'h10007, acc);
    idle(3, 1'b1);
`endif

    // Reset with two transactions in flight.
    step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0, acc);
    step(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_out_valid", 17'(out_valid), 17'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 17'(out_valid), 17'd0);
    chk("midrst_sum", {cout, sum}, 17'h0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 17'(in_ready), 17'd1);
    step(1'b1, 16'h0006, 16'h0006, 1'b0, 1'b0, 1'b1, 1'b1, 17'h0000C, acc);
    idle(3, 1'b1);

    // Randomised traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      logic rs;
`ifdef CSA_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      step(($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
           rs, ($urandom_range(0, 9) < 6), 1'b0, 17'h0, acc);
    end

    // Drain with a bounded budget.
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1, 1'b1);
    chk("drain_empty", 17'(q.size()), 17'd0);
    idle(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
